// File: rtl/neuron_mac.sv
// Purpose: streaming signed MAC neuron; sums a*w over one vector, rescales, adds bias, saturates to 32 bits.
// Latency: end beat accepted at edge T -> x_valid pulse in the cycle after edge T+2; in_ready low 2 cycles per vector.
// Backpressure: in_ready deasserts only while draining/emitting a result; no output backpressure (consumer always accepts).
module neuron_mac #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 42,
  parameter int FRAC_SHIFT = 10,
  parameter int N_MAX      = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              in_last,
  input  logic [31:0]       bias,
  output logic              x_valid,
  output logic [31:0]       x_data,
  output logic              sat
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(N_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_MAX - 1);

  // Saturation bounds expressed at the width of the biased sum.
  localparam logic signed [ACC_W:0] SAT_MAX = $signed({{(ACC_W - 30){1'b0}}, {31{1'b1}}});
  localparam logic signed [ACC_W:0] SAT_MIN = $signed({{(ACC_W - 30){1'b1}}, {31{1'b0}}});

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic [PROD_W-1:0]        prod_q, prod_d;
  logic                     p_v_q, p_v_d;
  logic                     p_last_q, p_last_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     first_q, first_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     x_valid_q, x_valid_d;
  logic [31:0]              x_data_q, x_data_d;
  logic                     sat_q, sat_d;

  logic                     accept;
  logic                     end_beat;
  logic [PROD_W-1:0]        a_ext;
  logic [PROD_W-1:0]        w_ext;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  t_shift;
  logic signed [ACC_W:0]    s_sum;

  assign in_ready = in_ready_q;
  assign x_valid  = x_valid_q;
  assign x_data   = x_data_q;
  assign sat      = sat_q;

  // Datapath helpers: operand/product sign extension, rescale and bias add.
  always_comb begin
    accept   = in_valid && in_ready_q;
    end_beat = in_last || (cnt_q == LAST_IDX);
    a_ext    = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    w_ext    = {{DATA_W{in_weight[DATA_W-1]}}, in_weight};
    prod_ext = $signed({{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q});
    t_shift  = acc_q >>> FRAC_SHIFT;
    s_sum    = $signed({t_shift[ACC_W-1], t_shift}) +
               $signed({{(ACC_W - 31){bias[31]}}, bias});
  end

  // Next-state: S1 multiply, S2 accumulate, and the ACC/DRAIN/OUT control FSM.
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    prod_d     = prod_q;
    p_v_d      = 1'b0;
    p_last_d   = 1'b0;
    acc_d      = acc_q;
    first_d    = first_q;
    cnt_d      = cnt_q;
    x_valid_d  = 1'b0;
    x_data_d   = x_data_q;
    sat_d      = sat_q;

    // S1: register the product of the accepted beat.
    if (accept) begin
      prod_d   = a_ext * w_ext;
      p_v_d    = 1'b1;
      p_last_d = end_beat;
    end

    // S2: the first product of a vector overwrites the stale sum.
    if (p_v_q) begin
      acc_d   = (first_q ? '0 : acc_q) + prod_ext;
      first_d = 1'b0;
    end

    case (state_q)
      ST_ACC: begin
        in_ready_d = 1'b1;
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (end_beat) begin
            state_d    = ST_DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        // The end-beat product sits in S1 during this cycle and lands in acc at its close.
        in_ready_d = 1'b0;
        if (p_v_q && p_last_q) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (s_sum > SAT_MAX) begin
          x_data_d = 32'h7FFF_FFFF;
          sat_d    = 1'b1;
        end else if (s_sum < SAT_MIN) begin
          x_data_d = 32'h8000_0000;
          sat_d    = 1'b1;
        end else begin
          x_data_d = s_sum[31:0];
          sat_d    = 1'b0;
        end
        x_valid_d  = 1'b1;
        in_ready_d = 1'b1;
        cnt_d      = '0;
        first_d    = 1'b1;
        state_d    = ST_ACC;
      end
      default: begin
        state_d    = ST_ACC;
        in_ready_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any partial vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_ACC;
      in_ready_q <= 1'b0;
      prod_q     <= '0;
      p_v_q      <= 1'b0;
      p_last_q   <= 1'b0;
      acc_q      <= '0;
      first_q    <= 1'b1;
      cnt_q      <= '0;
      x_valid_q  <= 1'b0;
      x_data_q   <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      prod_q     <= prod_d;
      p_v_q      <= p_v_d;
      p_last_q   <= p_last_d;
      acc_q      <= acc_d;
      first_q    <= first_d;
      cnt_q      <= cnt_d;
      x_valid_q  <= x_valid_d;
      x_data_q   <= x_data_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Purpose: self-checking bench for neuron_mac against a plain-arithmetic vector model.
// Latency: checks every result arrives in the cycle after edge T+2 of its end beat.
// Backpressure: beats are held until in_ready; in_ready low time is counted per vector.
module tb_neuron_mac;

  localparam int NM = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [15:0] in_weight = '0;
  logic        in_last = 1'b0;
  logic [31:0] bias = '0;
  logic        x_valid;
  logic [31:0] x_data;
  logic        sat;

  neuron_mac #(
    .DATA_W(16), .ACC_W(42), .FRAC_SHIFT(10), .N_MAX(NM)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last), .bias(bias),
    .x_valid(x_valid), .x_data(x_data), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    logic   sat;
    int     cyc;
  } res_t;

  int     cyc = 0;
  int     rdy_low = 0;
  int     errors = 0;
  int     checks = 0;
  res_t   obs_q[$];
  res_t   exp_q[$];
  longint m_sum = 0;
  int     m_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe results and in_ready-low cycles mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (x_valid === 1'b1) obs_q.push_back('{longint'($signed(x_data)), sat, cyc});
    if (reset && in_ready !== 1'b1) rdy_low++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: whole-vector sum, floor rescale by 2^10, bias, clamp to int32.
  function automatic res_t ref_result(longint sum, logic [31:0] b, int c);
    res_t   r;
    longint s;
    s = (sum >>> 10) + longint'($signed(b));
    if (s > 64'sh7FFF_FFFF) begin
      r.data = 64'sh7FFF_FFFF; r.sat = 1'b1;
    end else if (s < -64'sh8000_0000) begin
      r.data = -64'sh8000_0000; r.sat = 1'b1;
    end else begin
      r.data = s; r.sat = 1'b0;
    end
    r.cyc = c;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) tick();
  endtask

  // Offer one beat and hold it until accepted; in_valid stays high afterwards.
  task automatic beat(int a, int w, bit last);
    int g;
    in_valid  = 1'b1;
    in_data   = 16'(a);
    in_weight = 16'(w);
    in_last   = last;
    g = 0;
    while (in_ready !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    if (g >= 20) chk("in_ready_timeout", in_ready, 1);
    tick();
    m_sum += longint'(a) * longint'(w);
    m_n++;
    if (last || m_n == NM) begin
      exp_q.push_back(ref_result(m_sum, bias, cyc + 2));
      m_sum = 0;
      m_n = 0;
    end
  endtask

  // Wait for all expected results, then compare value, sat flag and arrival cycle.
  task automatic drain(string tag);
    int g;
    res_t o, e;
    idle(1);
    g = 0;
    while (obs_q.size() < exp_q.size() && g < 20) begin
      tick();
      g++;
    end
    repeat (4) tick();
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"}, o.data, e.data);
      chk({tag, "_sat"}, o.sat, e.sat);
      chk({tag, "_latency"}, o.cyc, e.cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int a, w, len, sel;
    bit lst;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_x_data", x_data, 0);
    chk("rst_sat", sat, 0);
    reset = 1'b1;
    tick();
    chk("in_ready_after_reset", in_ready, 1);

    // T1: four beats of 1.0*1.0 in Q10
    bias = 0;
    for (int i = 0; i < 4; i++) beat(1024, 1024, i == 3);
    drain("t1");

    // T2: negative product with bias, then floor behaviour of the shift
    bias = 32'd100;
    beat(-2048, 512, 1);
    drain("t2a");
    bias = 0;
    beat(-1, 1, 1);
    drain("t2b");

    // T3: positive saturation, then large negative bias without saturation
    bias = 32'h7FFF_FFFF;
    beat(32767, 32767, 1);
    drain("t3a");
    bias = 32'h8000_0000;
    beat(32767, 32767, 1);
    drain("t3b");

    // T4: forced end after N_MAX beats; the next beat opens a fresh vector
    bias = 0;
    for (int i = 0; i < NM; i++) beat(1024, 1024, 0);
    beat(1024, 1024, 1);
    drain("t4");

    // T5: reset after 3 of 5 beats discards the vector
    for (int i = 0; i < 3; i++) beat(1024, 1024, 0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_sum = 0;
    m_n = 0;
    beat(1024, 1024, 0);
    beat(1024, 1024, 1);
    drain("t5");

    // T6: back-to-back vectors with in_valid held high
    bias = 32'd7;
    idle(2);
    rdy_low = 0;
    for (int v = 0; v < 3; v++) begin
      len = (v == 1) ? 1 : v + 3;
      for (int i = 0; i < len; i++) begin
        a = int'($signed(16'($urandom)));
        w = int'($signed(16'($urandom)));
        beat(a, w, i == len - 1);
      end
    end
    drain("t6");
    chk("t6_ready_low_cycles", rdy_low, 6);

    // Randomized vectors with random gaps and biases, including saturation corners
    for (int v = 0; v < 40; v++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: bias = 32'h7FFF_F000;
        1: bias = 32'h8000_0800;
        default: bias = $urandom;
      endcase
      len = $urandom_range(1, NM);
      for (int i = 0; i < len; i++) begin
        a = int'($signed(16'($urandom)));
        w = int'($signed(16'($urandom)));
        lst = (i == len - 1) ? ((len == NM) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
        beat(a, w, lst);
        if ($urandom_range(0, 3) == 0 && i != len - 1) idle(1);
      end
      drain("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
